// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes, request-info
// field positions and the responder FSM states.
package dmem_responder_pkg;

  localparam logic [1:0] DSIZE_BYTE = 2'd0;
  localparam logic [1:0] DSIZE_HALF = 2'd1;
  localparam logic [1:0] DSIZE_ILL  = 2'd2;
  localparam logic [1:0] DSIZE_WORD = 2'd3;

  // Bit positions inside req_info, numbered MSB-first like the port.
  localparam int INFO_UNSIGNED = 0;
  localparam int INFO_DSIZE_HI = 1;
  localparam int INFO_DSIZE_LO = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic [2:0] dsize_bytes(input logic [1:0] dsize);
    case (dsize)
      DSIZE_WORD: return 3'd4;
      DSIZE_HALF: return 3'd2;
      default:    return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Load-side alignment: picks the big-endian field out of the 4-byte fetch,
// extends it, and flags illegal sizes and misaligned addresses.
module dmem_align
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  dsize,
  input  logic        is_unsigned,
  input  logic [31:0] raw,
  output logic [31:0] ext_data,
  output logic        align_err
);

  // raw[31:24] always holds mem[addr]; narrower fields start there.
  always_comb begin
    ext_data  = raw;
    align_err = 1'b0;
    case (dsize)
      DSIZE_BYTE: ext_data = {{24{~is_unsigned & raw[31]}}, raw[31:24]};
      DSIZE_HALF: begin
        ext_data  = {{16{~is_unsigned & raw[31]}}, raw[31:16]};
        align_err = addr_lo[0];
      end
      DSIZE_WORD: align_err = |addr_lo;
      DSIZE_ILL: begin
        ext_data  = '0;
        align_err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Variable-latency request/response data memory: big-endian byte array,
// access performed at the acceptance edge, response LATENCY edges later.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int SIZE    = 32768,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [0:31] req_addr,
  input  logic [0:31] req_wdata,
  input  logic [0:2]  req_info,
  output logic        resp_valid,
  output logic [0:31] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int         AW       = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  logic [7:0] mem [0:SIZE-1];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0]   addr, wdata, wdata_sh, raw, ext_data;
  logic [1:0]    dsize;
  logic          is_unsigned;
  logic [2:0]    nbytes;
  logic [32:0]   last_byte;
  logic          range_err, align_err, req_err, accept, mem_we;
  logic [AW-1:0] base;
  logic [3:0]    lane_en;

  assign addr        = req_addr;
  assign wdata       = req_wdata;
  assign dsize       = req_info[INFO_DSIZE_HI:INFO_DSIZE_LO];
  assign is_unsigned = req_info[INFO_UNSIGNED];
  assign nbytes      = dsize_bytes(dsize);
  assign base        = addr[AW-1:0];

  // 33-bit sum so an address near 2^32 cannot wrap back into range.
  assign last_byte = {1'b0, addr} + {30'd0, nbytes} - 33'd1;
  assign range_err = last_byte >= 33'(SIZE);
  assign req_err   = align_err | range_err;
  assign accept    = req_valid & ready_q;
  assign mem_we    = accept & req_we & ~req_err;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign raw[31-8*gi -: 8] = mem[base + AW'(gi)];
    assign lane_en[gi]       = 3'(gi) < nbytes;
  end

  always_comb begin
    case (dsize)
      DSIZE_HALF: wdata_sh = {wdata[15:0], 16'h0};
      DSIZE_WORD: wdata_sh = wdata;
      default:    wdata_sh = {wdata[7:0], 24'h0};
    endcase
  end

  dmem_align u_align (
    .addr_lo     (addr[1:0]),
    .dsize       (dsize),
    .is_unsigned (is_unsigned),
    .raw         (raw),
    .ext_data    (ext_data),
    .align_err   (align_err)
  );

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[base + AW'(i)] <= wdata_sh[31-8*i -: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_RESP;
      end
      default: begin
        if (accept) begin
          err_d   = req_err;
          rdata_d = (req_err | req_we) ? '0 : ext_data;
          if (LATENCY == 1) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = LAT_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
    ready_d = state_d != ST_WAIT;
    valid_d = state_d == ST_RESP;
    busy_d  = state_d == ST_WAIT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (LATENCY 1, 2, 3), each
// checked against a byte-array reference model and a response-cycle budget.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int SIZE = 32768;
  localparam int ND   = 3;

  typedef struct packed {
    logic [31:0] acc;
    logic [31:0] due;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        rv     [ND];
  logic        rwe    [ND];
  logic [31:0] raddr  [ND];
  logic [31:0] rwdata [ND];
  logic [2:0]  rinfo  [ND];
  logic        rdy    [ND];
  logic        vld    [ND];
  logic        rerr   [ND];
  logic        bsy    [ND];
  logic [31:0] rdata  [ND];

  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_miss = 0;
  exp_t sb [ND][$];
  logic [7:0] mm [ND][SIZE];

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    dmem_responder #(.SIZE(SIZE), .LATENCY(gi + 1)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (rv[gi]),
      .req_ready  (rdy[gi]),
      .req_we     (rwe[gi]),
      .req_addr   (raddr[gi]),
      .req_wdata  (rwdata[gi]),
      .req_info   (rinfo[gi]),
      .resp_valid (vld[gi]),
      .resp_rdata (rdata[gi]),
      .resp_err   (rerr[gi]),
      .busy       (bsy[gi])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int d, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s dut%0d cyc=%0d: got %08h, expected %08h", name, d, cyc, act, req);
    end
  endfunction

  // Reference model: plain big-endian byte arithmetic over an array.
  function automatic void model(input int d, input bit we, input logic [31:0] a, input logic [31:0] wd,
                                input logic [2:0] info, output logic [31:0] r, output bit e);
    int     n;
    int     ds;
    bit     uns;
    longint v;
    longint last;
    ds   = int'(info[1:0]);
    uns  = info[2];
    n    = (ds == 3) ? 4 : (ds == 1) ? 2 : 1;
    last = longint'({32'b0, a}) + longint'(n) - 1;
    e = (ds == 2) || (ds == 1 && a[0]) || (ds == 3 && a[1:0] != 2'b00) || (last >= SIZE);
    r = 32'h0;
    if (e) return;
    if (we) begin
      for (int k = 0; k < n; k++) mm[d][int'(a) + k] = 8'(wd >> (8 * (n - 1 - k)));
    end else begin
      v = 0;
      for (int k = 0; k < n; k++) v = v * 256 + longint'(mm[d][int'(a) + k]);
      if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
      r = v[31:0];
    end
  endfunction

  // Called at a negedge; returns at the negedge after the acceptance edge
  // with req_valid still high so the caller can chain back-to-back requests.
  task automatic issue(input int d, input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] info, input bit use_exp, input logic [31:0] xr, input bit xe);
    logic [31:0] mr;
    bit          me;
    exp_t        e;
    int          guard;
    rv[d] = 1'b1; rwe[d] = we; raddr[d] = a; rwdata[d] = wd; rinfo[d] = info;
    guard = 0;
    while (rdy[d] !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (rdy[d] !== 1'b1) begin
      n_vec++; n_miss++;
      $display("FAIL accept_timeout dut%0d cyc=%0d: req_ready stayed %0b, required 1", d, cyc, rdy[d]);
      rv[d] = 1'b0;
      return;
    end
    model(d, we, a, wd, info, mr, me);
    e.acc   = 32'(cyc);
    e.due   = 32'(cyc + d + 1);
    e.rdata = use_exp ? xr : mr;
    e.err   = use_exp ? xe : me;
    sb[d].push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int d, input int n);
    rv[d] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: timing, busy/ready shape and response contents per instance.
  always @(negedge clk) begin : monitor
    exp_t e;
    logic eb;
    for (int d = 0; d < ND; d++) begin
      while (sb[d].size() > 0 && int'(sb[d][0].due) < cyc) begin
        n_vec++; n_miss++;
        $display("FAIL resp_missing dut%0d cyc=%0d: no resp_valid, required at cyc %0d", d, cyc, sb[d][0].due);
        void'(sb[d].pop_front());
      end
      eb = sb[d].size() > 0 && int'(sb[d][0].acc) < cyc && cyc < int'(sb[d][0].due);
      chk("busy", d, {31'b0, bsy[d]}, {31'b0, eb});
      chk("req_ready", d, {31'b0, rdy[d]}, {31'b0, ~eb});
      if (vld[d] !== 1'b0) begin
        if (sb[d].size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL resp_unexpected dut%0d cyc=%0d: resp_valid=%0b rdata=%08h, required no response",
                   d, cyc, vld[d], rdata[d]);
        end else begin
          e = sb[d].pop_front();
          chk("resp_cycle", d, 32'(cyc), e.due);
          chk("resp_rdata", d, rdata[d], e.rdata);
          chk("resp_err", d, {31'b0, rerr[d]}, {31'b0, e.err});
          $display("dut%0d cyc %0d resp rdata=%08h err=%0b", d, cyc, rdata[d], rerr[d]);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0]  x22;
    logic [31:0] a;
    int          r;
    for (int d = 0; d < ND; d++) begin
      rv[d] = 1'b0; rwe[d] = 1'b0; raddr[d] = '0; rwdata[d] = '0; rinfo[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk("rst_ready", d, {31'b0, rdy[d]}, 32'd1);
      chk("rst_valid", d, {31'b0, vld[d]}, 32'd0);
      chk("rst_rdata", d, rdata[d], 32'd0);
      chk("rst_err", d, {31'b0, rerr[d]}, 32'd0);
      chk("rst_busy", d, {31'b0, bsy[d]}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Known contents for every region later loaded from.
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < 256; i += 4) issue(d, 1'b1, 32'(i), $urandom, 3'b011, 1'b0, 32'h0, 1'b0);
      for (int i = SIZE - 16; i < SIZE; i += 4) issue(d, 1'b1, 32'(i), $urandom, 3'b011, 1'b0, 32'h0, 1'b0);
      idle(d, 1);
    end

    issue(1, 1'b1, 32'h10, 32'hDEADBEEF, 3'b011, 1'b1, 32'h0, 1'b0);
    issue(1, 1'b0, 32'h10, 32'h0, 3'b011, 1'b1, 32'hDEADBEEF, 1'b0);
    issue(1, 1'b0, 32'h11, 32'h0, 3'b000, 1'b1, 32'hFFFFFFAD, 1'b0);
    issue(1, 1'b0, 32'h11, 32'h0, 3'b100, 1'b1, 32'h000000AD, 1'b0);
    issue(1, 1'b0, 32'h12, 32'h0, 3'b001, 1'b1, 32'hFFFFBEEF, 1'b0);
    issue(1, 1'b0, 32'h12, 32'h0, 3'b101, 1'b1, 32'h0000BEEF, 1'b0);
    issue(1, 1'b1, 32'h20, 32'h00001234, 3'b001, 1'b1, 32'h0, 1'b0);
    issue(1, 1'b1, 32'h23, 32'h000000AB, 3'b000, 1'b1, 32'h0, 1'b0);
    x22 = mm[1][32'h22];
    issue(1, 1'b0, 32'h20, 32'h0, 3'b011, 1'b1, {16'h1234, x22, 8'hAB}, 1'b0);
    issue(1, 1'b0, 32'h21, 32'h0, 3'b001, 1'b1, 32'h0, 1'b1);
    issue(1, 1'b1, 32'h22, 32'hFFFFFFFF, 3'b011, 1'b1, 32'h0, 1'b1);
    issue(1, 1'b1, 32'h21, 32'hFFFFFFFF, 3'b001, 1'b1, 32'h0, 1'b1);
    issue(1, 1'b0, 32'h20, 32'h0, 3'b010, 1'b1, 32'h0, 1'b1);
    issue(1, 1'b1, 32'h20, 32'hFFFFFFFF, 3'b010, 1'b1, 32'h0, 1'b1);
    issue(1, 1'b0, 32'(SIZE - 2), 32'h0, 3'b011, 1'b1, 32'h0, 1'b1);
    issue(1, 1'b1, 32'(SIZE - 2), 32'hFFFFFFFF, 3'b011, 1'b1, 32'h0, 1'b1);
    issue(1, 1'b0, 32'hFFFFFFFE, 32'h0, 3'b001, 1'b1, 32'h0, 1'b1);
    issue(1, 1'b0, 32'h20, 32'h0, 3'b011, 1'b1, {16'h1234, x22, 8'hAB}, 1'b0);
    issue(1, 1'b0, 32'(SIZE - 4), 32'h0, 3'b011, 1'b0, 32'h0, 1'b0);
    issue(1, 1'b1, 32'(SIZE - 2), 32'h0000CAFE, 3'b001, 1'b1, 32'h0, 1'b0);
    issue(1, 1'b0, 32'(SIZE - 1), 32'h0, 3'b000, 1'b1, 32'hFFFFFFFE, 1'b0);
    idle(1, 2);

    // LATENCY=1 with req_valid held: one acceptance per edge.
    for (int i = 0; i < 8; i++) issue(0, 1'b1, 32'(8'h40 + 4 * i), $urandom, 3'b011, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) issue(0, 1'b0, 32'(8'h40 + 4 * i), 32'h0, 3'b011, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) issue(0, 1'b0, 32'(8'h40 + i), 32'h0, {1'b0, 2'b00}, 1'b0, 32'h0, 1'b0);
    idle(0, 2);

    // Reset while the LATENCY=3 instance sits in WAIT.
    issue(2, 1'b0, 32'h10, 32'h0, 3'b011, 1'b0, 32'h0, 1'b0);
    rv[2] = 1'b0;
    #2 rst_n = 1'b0;
    sb[2].delete();
    #1;
    chk("midrst_ready", 2, {31'b0, rdy[2]}, 32'd1);
    chk("midrst_valid", 2, {31'b0, vld[2]}, 32'd0);
    chk("midrst_rdata", 2, rdata[2], 32'd0);
    chk("midrst_err", 2, {31'b0, rerr[2]}, 32'd0);
    chk("midrst_busy", 2, {31'b0, bsy[2]}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    for (int d = 0; d < ND; d++) begin
      for (int n = 0; n < 70; n++) begin
        r = int'($urandom_range(0, 9));
        if (r < 7) a = 32'($urandom_range(0, 255));
        else if (r < 9) a = 32'(SIZE - 12) + 32'($urandom_range(0, 15));
        else a = 32'hFFFFFFFE;
        issue(d, 1'($urandom_range(0, 1)), a, $urandom,
              {1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))}, 1'b0, 32'h0, 1'b0);
        if ($urandom_range(0, 2) == 0) idle(d, int'($urandom_range(0, 2)));
      end
      idle(d, 0);
    end

    repeat (20) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      n_vec++;
      if (sb[d].size() != 0) begin
        n_miss++;
        $display("FAIL drain dut%0d: %0d responses outstanding, required 0", d, sb[d].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Request/response data-memory responder with variable latency, replacing the zero-latency combinational data memory behind the MEM stage.
- Accepts one load/store per handshake and performs big-endian byte/halfword/word access with alignment checking.
- Returns sign- or zero-extended load data after LATENCY cycles.
- Drives a busy indication that the pipeline uses to assert reg_lock.

Parameters:
SIZE, 32768, memory size in bytes; byte array indexed 0..SIZE-1
LATENCY, 2, cycles from acceptance edge to response; legal range 1..15

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  responder can accept; a request transfers on an edge where req_valid & req_ready
req_we  in  1  1 = store, 0 = load
req_addr  in  [0:31]  byte address
req_wdata  in  [0:31]  store data (bit 0 = MSB)
req_info  in  [0:2]  [0] = unsigned load, [1:2] = dsize (3 word, 1 half, 0 byte, 2 illegal)
resp_valid  out  1  one-cycle response pulse; no backpressure
resp_rdata  out  [0:31]  extended load data; 0 for stores and errors
resp_err  out  1  request faulted; qualified by resp_valid
busy  out  1  request in flight (state != IDLE and not RESP)

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; busy=0.
  - Memory contents are not reset.
  - An in-flight response is dropped; a store committed at its acceptance edge stays committed.
- States: IDLE, WAIT, RESP.
  - req_ready=1 in IDLE and RESP, 0 in WAIT.
- Acceptance edge (req_valid & req_ready): the memory access is performed at this edge.
  - Store: bytes written.
  - Load: extended data captured into the response register.
  - Error checks are evaluated on the request values.
- Response timing: resp_valid is high for exactly one cycle, in the cycle following the LATENCY-th rising edge, counting the acceptance edge as 1.
  - LATENCY=1: accept → RESP.
  - LATENCY>1: accept → WAIT, with a counter loaded to LATENCY-1 and decremented each edge; reaching 0 → RESP.
- From RESP: a new accepted request follows the acceptance rules above; otherwise → IDLE. Back-to-back throughput is one request per LATENCY cycles.
- Byte order is big-endian: mem[a] is most significant.
  - Word: {mem[a..a+3]} <-> wdata[0:31].
  - Half: {mem[a],mem[a+1]} <-> bits [16:31].
  - Byte: mem[a] <-> bits [24:31].
- Load extension:
  - Half/byte sign-extend from the MSB of the fetched field when req_info[0]=0; zero-extend when req_info[0]=1.
  - Word ignores req_info[0].
- Errors (resp_err=1, no memory write, resp_rdata=0):
  - dsize=2.
  - Half with addr[31]=1.
  - Word with addr[30:31]!=0.
  - addr+bytes-1 >= SIZE (computed without 32-bit wrap).
- Stores return resp_rdata=0, resp_err=0 when legal.
- resp_rdata and resp_err hold their last values outside resp_valid. Benches check them only while resp_valid=1.
- req_valid low while ready: no state change.

Decomposition:
- Shared package holds:
  - dsize constants DSIZE_BYTE=0, DSIZE_HALF=1, DSIZE_WORD=3.
  - req_info field indices.
  - State encoding IDLE/WAIT/RESP.
- One combinational sub-module, dmem_align: takes addr low bits, dsize, unsigned flag and the raw 32-bit fetch; produces the extended load data and the misalign error.
- The FSM, counter and byte array stay in dmem_responder.

Test Plan:
- Reset mid-WAIT (LATENCY=3): pull rst_n low one cycle after acceptance → outputs immediately 0, req_ready=1, no resp_valid pulse after release.
- Word store 0xDEADBEEF @0x10, then word load @0x10 (LATENCY=2):
  - resp_valid exactly 2 cycles after each acceptance edge.
  - Load returns 0xDEADBEEF.
  - busy high the intervening cycle.
- Byte load @0x11 signed → 0xFFFFFFAD; unsigned → 0x000000AD. Half load @0x12 signed → 0xFFFFBEEF.
- Half store 0x00001234 @0x20, then byte store 0x000000AB @0x23 → word load @0x20 returns 0x1234XXAB, where XX is the prior mem[0x22].
- Errors: half load @0x21, word store @0x22, dsize=2, word @SIZE-2 → each resp_err=1, resp_rdata=0, and memory is unchanged (verified by a follow-up load).
- Back-to-back with req_valid held and LATENCY=1: a new request accepted in every RESP cycle → resp_valid high continuously with correct per-request data; req_ready never drops.
